// File: rtl/axi4_lite_master.sv
// rtl/axi4_lite_master.sv - single-outstanding AXI4-Lite master, one read or write at a time
// All handshake outputs are registered; a request is accepted only from IDLE.
module axi4_lite_master #(
  parameter int AXI_ADDR_WIDTH = 64,
  parameter int AXI_DATA_WIDTH = 32
) (
  input  logic                          clk_i,
  input  logic                          arst_i,
  input  logic                          start_read_i,
  input  logic                          start_write_i,
  input  logic [AXI_ADDR_WIDTH-1:0]     addr_i,
  input  logic [AXI_DATA_WIDTH-1:0]     data_i,
  input  logic [AXI_DATA_WIDTH/8-1:0]   strb_i,
  output logic [AXI_DATA_WIDTH-1:0]     data_o,
  output logic                          done_o,
  output logic                          error_o,
  output logic                          busy_o,
  output logic                          AR_VALID,
  output logic [AXI_ADDR_WIDTH-1:0]     AR_ADDR,
  output logic [2:0]                    AR_PROT,
  input  logic                          AR_READY,
  input  logic [AXI_DATA_WIDTH-1:0]     R_DATA,
  input  logic [1:0]                    R_RESP,
  input  logic                          R_VALID,
  output logic                          R_READY,
  output logic                          AW_VALID,
  output logic [AXI_ADDR_WIDTH-1:0]     AW_ADDR,
  output logic [2:0]                    AW_PROT,
  input  logic                          AW_READY,
  output logic [AXI_DATA_WIDTH-1:0]     W_DATA,
  output logic [AXI_DATA_WIDTH/8-1:0]   W_STRB,
  output logic                          W_VALID,
  input  logic                          W_READY,
  input  logic [1:0]                    B_RESP,
  input  logic                          B_VALID,
  output logic                          B_READY
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RD_ADDR = 3'd1,
    RD_DATA = 3'd2,
    WR_REQ  = 3'd3,
    WR_RESP = 3'd4
  } state_t;

  state_t                        state;
  logic [AXI_ADDR_WIDTH-1:0]     addr_q;
  logic                          aw_done;
  logic                          w_done;
  logic                          aw_hs;
  logic                          w_hs;
  logic                          aw_done_n;
  logic                          w_done_n;

  assign AR_ADDR = addr_q;
  assign AW_ADDR = addr_q;
  assign AR_PROT = 3'b000;
  assign AW_PROT = 3'b000;

  // Look-ahead flags so a same-cycle AW and W handshake still moves to WR_RESP.
  assign aw_hs     = AW_VALID & AW_READY;
  assign w_hs      = W_VALID & W_READY;
  assign aw_done_n = aw_done | aw_hs;
  assign w_done_n  = w_done | w_hs;

  always_ff @(posedge clk_i) begin
    if (arst_i) begin
      state    <= IDLE;
      addr_q   <= '0;
      W_DATA   <= '0;
      W_STRB   <= '0;
      data_o   <= '0;
      done_o   <= 1'b0;
      error_o  <= 1'b0;
      busy_o   <= 1'b0;
      AR_VALID <= 1'b0;
      R_READY  <= 1'b0;
      AW_VALID <= 1'b0;
      W_VALID  <= 1'b0;
      B_READY  <= 1'b0;
      aw_done  <= 1'b0;
      w_done   <= 1'b0;
    end else begin
      done_o  <= 1'b0;
      error_o <= 1'b0;
      case (state)
        IDLE: begin
          if (start_read_i) begin
            addr_q   <= addr_i;
            AR_VALID <= 1'b1;
            busy_o   <= 1'b1;
            state    <= RD_ADDR;
          end else if (start_write_i) begin
            addr_q   <= addr_i;
            W_DATA   <= data_i;
            W_STRB   <= strb_i;
            AW_VALID <= 1'b1;
            W_VALID  <= 1'b1;
            aw_done  <= 1'b0;
            w_done   <= 1'b0;
            busy_o   <= 1'b1;
            state    <= WR_REQ;
          end
        end
        RD_ADDR: begin
          if (AR_READY) begin
            AR_VALID <= 1'b0;
            R_READY  <= 1'b1;
            state    <= RD_DATA;
          end
        end
        RD_DATA: begin
          if (R_VALID) begin
            R_READY <= 1'b0;
            data_o  <= R_DATA;
            done_o  <= 1'b1;
            error_o <= (R_RESP != 2'b00);
            busy_o  <= 1'b0;
            state   <= IDLE;
          end
        end
        WR_REQ: begin
          if (aw_hs) begin
            AW_VALID <= 1'b0;
            aw_done  <= 1'b1;
          end
          if (w_hs) begin
            W_VALID <= 1'b0;
            w_done  <= 1'b1;
          end
          if (aw_done_n && w_done_n) begin
            B_READY <= 1'b1;
            state   <= WR_RESP;
          end
        end
        WR_RESP: begin
          if (B_VALID) begin
            B_READY <= 1'b0;
            done_o  <= 1'b1;
            error_o <= (B_RESP != 2'b00);
            aw_done <= 1'b0;
            w_done  <= 1'b0;
            busy_o  <= 1'b0;
            state   <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axi4_lite_master.sv
// tb/tb_axi4_lite_master.sv - directed bench with a cycle-schedule model of the AXI4-Lite master
module tb_axi4_lite_master;
  localparam int AW = 64;
  localparam int DW = 32;
  localparam int SW = DW / 8;
  localparam int N  = 1024;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          arst_i, start_read_i, start_write_i;
  logic [AW-1:0] addr_i;
  logic [DW-1:0] data_i;
  logic [SW-1:0] strb_i;
  logic [DW-1:0] data_o;
  logic          done_o, error_o, busy_o;
  logic          AR_VALID, AR_READY, R_VALID, R_READY;
  logic [AW-1:0] AR_ADDR, AW_ADDR;
  logic [2:0]    AR_PROT, AW_PROT;
  logic [DW-1:0] R_DATA, W_DATA;
  logic [1:0]    R_RESP, B_RESP;
  logic          AW_VALID, AW_READY, W_VALID, W_READY, B_VALID, B_READY;
  logic [SW-1:0] W_STRB;

  axi4_lite_master #(.AXI_ADDR_WIDTH(AW), .AXI_DATA_WIDTH(DW)) dut (
    .clk_i(clk), .arst_i(arst_i), .start_read_i(start_read_i), .start_write_i(start_write_i),
    .addr_i(addr_i), .data_i(data_i), .strb_i(strb_i), .data_o(data_o), .done_o(done_o),
    .error_o(error_o), .busy_o(busy_o),
    .AR_VALID(AR_VALID), .AR_ADDR(AR_ADDR), .AR_PROT(AR_PROT), .AR_READY(AR_READY),
    .R_DATA(R_DATA), .R_RESP(R_RESP), .R_VALID(R_VALID), .R_READY(R_READY),
    .AW_VALID(AW_VALID), .AW_ADDR(AW_ADDR), .AW_PROT(AW_PROT), .AW_READY(AW_READY),
    .W_DATA(W_DATA), .W_STRB(W_STRB), .W_VALID(W_VALID), .W_READY(W_READY),
    .B_RESP(B_RESP), .B_VALID(B_VALID), .B_READY(B_READY)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Expected value of every output for every cycle, filled per transaction.
  logic          exp_arv[N], exp_rr[N], exp_awv[N], exp_wv[N], exp_br[N];
  logic          exp_done[N], exp_err[N], exp_busy[N];
  logic [AW-1:0] exp_araddr[N], exp_awaddr[N];
  logic [DW-1:0] exp_wdata[N], exp_data[N];
  logic [SW-1:0] exp_wstrb[N];

  int n_cmp = 0;
  int n_bad = 0;
  bit cmp_en = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      if (n_bad <= 40) $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  function automatic void clear_from(input int c0);
    for (int c = c0; c < N; c++) begin
      exp_arv[c] = 0; exp_rr[c] = 0; exp_awv[c] = 0; exp_wv[c] = 0; exp_br[c] = 0;
      exp_done[c] = 0; exp_err[c] = 0; exp_busy[c] = 0;
      exp_araddr[c] = '0; exp_awaddr[c] = '0; exp_wdata[c] = '0; exp_wstrb[c] = '0;
      exp_data[c] = '0;
    end
  endfunction

  // Read started in cycle s: AR for da+1 cycles, R wait dr cycles, done 3+da+dr after start.
  function automatic void sched_read(input int s, input logic [AW-1:0] a, input int da, input int dr,
                                     input logic [DW-1:0] rd, input logic [1:0] rr);
    int d = s + 3 + da + dr;
    for (int c = s + 1; c <= s + 1 + da; c++) begin exp_arv[c] = 1; exp_araddr[c] = a; end
    for (int c = s + 2 + da; c < d; c++) exp_rr[c] = 1;
    for (int c = s + 1; c < d; c++) exp_busy[c] = 1;
    exp_done[d] = 1;
    exp_err[d]  = (rr != 2'b00);
    for (int c = d; c < N; c++) exp_data[c] = rd;
  endfunction

  function automatic void sched_write(input int s, input logic [AW-1:0] a, input logic [DW-1:0] wd,
                                      input logic [SW-1:0] st, input int daw, input int dw,
                                      input int db, input logic [1:0] br);
    int m = (daw > dw) ? daw : dw;
    int d = s + 3 + m + db;
    for (int c = s + 1; c <= s + 1 + daw; c++) begin exp_awv[c] = 1; exp_awaddr[c] = a; end
    for (int c = s + 1; c <= s + 1 + dw; c++) begin exp_wv[c] = 1; exp_wdata[c] = wd; exp_wstrb[c] = st; end
    for (int c = s + 2 + m; c < d; c++) exp_br[c] = 1;
    for (int c = s + 1; c < d; c++) exp_busy[c] = 1;
    exp_done[d] = 1;
    exp_err[d]  = (br != 2'b00);
  endfunction

  always @(negedge clk) begin
    if (cmp_en && cyc >= 1 && cyc < N) begin
      chk("ar_valid", AR_VALID, exp_arv[cyc]);
      if (exp_arv[cyc]) chk("ar_addr", AR_ADDR, exp_araddr[cyc]);
      chk("ar_prot", AR_PROT, 0);
      chk("r_ready", R_READY, exp_rr[cyc]);
      chk("aw_valid", AW_VALID, exp_awv[cyc]);
      if (exp_awv[cyc]) chk("aw_addr", AW_ADDR, exp_awaddr[cyc]);
      chk("aw_prot", AW_PROT, 0);
      chk("w_valid", W_VALID, exp_wv[cyc]);
      if (exp_wv[cyc]) begin
        chk("w_data", W_DATA, exp_wdata[cyc]);
        chk("w_strb", W_STRB, exp_wstrb[cyc]);
      end
      chk("b_ready", B_READY, exp_br[cyc]);
      chk("done", done_o, exp_done[cyc]);
      chk("error", error_o, exp_err[cyc]);
      chk("busy", busy_o, exp_busy[cyc]);
      chk("data_o", data_o, exp_data[cyc]);
    end
  end

  int n_aw = 0, n_w = 0, n_done = 0, last_done = -1;
  always @(negedge clk) begin
    if (cmp_en) begin
      if (AW_VALID) n_aw++;
      if (W_VALID) n_w++;
      if (done_o) begin n_done++; last_done = cyc; end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    @(negedge clk);
    #1;
  endtask

  task automatic do_read(input logic [AW-1:0] a, input int da, input int dr,
                         input logic [DW-1:0] rd, input logic [1:0] rr, input bit keep);
    int s = cyc;
    int d = s + 3 + da + dr;
    sched_read(s, a, da, dr, rd, rr);
    addr_i = a; start_read_i = 1; AR_READY = 0; R_VALID = 0;
    for (int c = s + 1; c <= d; c++) begin
      tick();
      if (!keep) start_read_i = 0;
      addr_i   = {$urandom, $urandom};
      AR_READY = (c == s + 1 + da);
      R_VALID  = (c == s + 2 + da + dr);
      R_DATA   = R_VALID ? rd : $urandom;
      R_RESP   = R_VALID ? rr : 2'($urandom);
    end
  endtask

  task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] wd, input logic [SW-1:0] st,
                          input int daw, input int dw, input int db, input logic [1:0] br);
    int s = cyc;
    int m = (daw > dw) ? daw : dw;
    int d = s + 3 + m + db;
    sched_write(s, a, wd, st, daw, dw, db, br);
    addr_i = a; data_i = wd; strb_i = st; start_write_i = 1;
    AW_READY = 0; W_READY = 0; B_VALID = 0;
    for (int c = s + 1; c <= d; c++) begin
      tick();
      start_write_i = 0;
      addr_i   = {$urandom, $urandom};
      data_i   = $urandom;
      strb_i   = SW'($urandom);
      AW_READY = (c == s + 1 + daw);
      W_READY  = (c == s + 1 + dw);
      B_VALID  = (c == s + 2 + m + db);
      B_RESP   = B_VALID ? br : 2'($urandom);
    end
  endtask

  int s0, a0, w0, d0;

  initial begin
    clear_from(0);
    arst_i = 1; start_read_i = 0; start_write_i = 0;
    addr_i = '0; data_i = '0; strb_i = '0;
    AR_READY = 0; R_VALID = 0; R_DATA = '0; R_RESP = '0;
    AW_READY = 0; W_READY = 0; B_VALID = 0; B_RESP = '0;
    tick();
    cmp_en = 1;
    tick();
    arst_i = 0;
    settle();
    chk("rst_busy", busy_o, 0);
    chk("rst_data", data_o, 0);
    chk("rst_ar_valid", AR_VALID, 0);

    // Plain read, zero wait states.
    s0 = cyc;
    do_read(64'h0000_1234_5678_9ABC, 0, 0, 32'hDEADBEEF, 2'b00, 0);
    settle();
    chk("rd_latency", last_done - s0, 3);
    chk("rd_done", done_o, 1);
    chk("rd_error", error_o, 0);
    chk("rd_data", data_o, 32'hDEADBEEF);

    // Write: AW accepted on its 4th valid cycle, W immediately.
    a0 = n_aw; w0 = n_w; d0 = n_done;
    do_write(64'hA000_0000_0000_0010, 32'h1122_3344, 4'b0101, 3, 0, 1, 2'b00);
    settle();
    chk("wr_aw_cycles", n_aw - a0, 4);
    chk("wr_w_cycles", n_w - w0, 1);
    chk("wr_done_count", n_done - d0, 1);
    chk("wr_data_held", data_o, 32'hDEADBEEF);

    // Both starts together: read first, write only after the read completes.
    a0 = n_aw;
    start_write_i = 1;
    data_i = 32'h5A5A_0F0F; strb_i = 4'b1111;
    do_read(64'h0000_0000_0000_0040, 1, 2, 32'h0BAD_F00D, 2'b01, 0);
    chk("both_no_early_aw", n_aw - a0, 0);
    do_write(64'h0000_0000_0000_0080, 32'hCAFE_1234, 4'b1000, 0, 2, 0, 2'b00);
    settle();
    chk("both_wr_data", data_o, 32'h0BAD_F00D);

    // SLVERR on B: done and error together.
    do_write(64'h0000_0000_0000_00C0, 32'h0000_FFFF, 4'b0011, 1, 1, 2, 2'b10);
    settle();
    chk("slverr_done", done_o, 1);
    chk("slverr_error", error_o, 1);

    // Back-to-back reads with start held; second AR waits 3 cycles for READY.
    s0 = cyc;
    do_read(64'h0000_0000_0000_0100, 0, 0, 32'h1111_2222, 2'b00, 1);
    do_read(64'h0000_0000_0000_0200, 3, 1, 32'h3333_4444, 2'b00, 0);
    settle();
    chk("b2b_second_done", last_done - s0, 10);
    chk("b2b_data", data_o, 32'h3333_4444);

    // Reset while waiting for R_VALID.
    d0 = n_done;
    s0 = cyc;
    sched_read(s0, 64'h0000_0000_0000_0300, 0, 20, 32'h5555_AAAA, 2'b00);
    addr_i = 64'h0000_0000_0000_0300; start_read_i = 1; AR_READY = 0; R_VALID = 0;
    tick(); start_read_i = 0; AR_READY = 1;
    tick(); AR_READY = 0;
    tick(); arst_i = 1; clear_from(s0 + 4);
    tick(); arst_i = 0;
    settle();
    chk("rst_mid_r_ready", R_READY, 0);
    chk("rst_mid_busy", busy_o, 0);
    chk("rst_mid_done", done_o, 0);
    chk("rst_mid_data", data_o, 0);
    tick(); tick();
    chk("rst_mid_no_done", n_done - d0, 0);

    do_read(64'h0000_0000_0000_0400, 0, 0, 32'hCAFE_F00D, 2'b00, 0);
    settle();
    chk("post_rst_data", data_o, 32'hCAFE_F00D);
    tick(); tick();
    cmp_en = 0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
